// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter that shares one FIFO write port between NumReq packet sources.
// Define FIFO_ARB_STARVE_EN to build the per-requester starvation counters behind `starve`.
module fifo_wr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned IdxWidth    = $clog2(NumReq),
  parameter int unsigned StarveLimit = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NumReq-1:0]           req_valid,
  input  logic [NumReq*DataWidth-1:0] req_data,
  input  logic [NumReq-1:0]           req_last,
  output logic [NumReq-1:0]           req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_writeEn,
  output logic [DataWidth-1:0]        fifo_writeData,
  output logic                        grant_valid,
  output logic [IdxWidth-1:0]         grant_idx,
  output logic [NumReq-1:0]           starve
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q;
  logic [IdxWidth-1:0] owner_q;
  logic [IdxWidth-1:0] last_grant_q;
  logic [IdxWidth-1:0] pick;
  logic [IdxWidth-1:0] cand;
  logic                locked;
  logic                grab;
  logic [DataWidth-1:0] slice [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_slice
    assign slice[g] = req_data[g*DataWidth +: DataWidth];
  end

  assign locked = (state_q == StLocked);
  assign grab   = (state_q == StIdle) && (|req_valid);

  // Walk downward so the nearest valid requester after last_grant_q wins.
  always_comb begin
    pick = last_grant_q;
    cand = '0;
    for (int unsigned k = NumReq; k > 0; k--) begin
      cand = IdxWidth'((32'(last_grant_q) + k) % NumReq);
      if (req_valid[cand]) pick = cand;
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && locked && !fifo_full) req_ready[owner_q] = 1'b1;
  end

  assign fifo_writeEn   = !rst && locked && req_valid[owner_q] && !fifo_full;
  assign fifo_writeData = slice[owner_q];
  assign grant_valid    = locked;
  assign grant_idx      = owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_grant_q <= IdxWidth'(NumReq - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grab) begin
            owner_q <= pick;
            state_q <= StLocked;
          end
        end
        StLocked: begin
          // Gaps and back-pressure keep the lock; only an accepted last beat releases it.
          if (fifo_writeEn && req_last[owner_q]) begin
            state_q      <= StIdle;
            last_grant_q <= owner_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIFO_ARB_STARVE_EN
  localparam int unsigned CntWidth = $clog2(StarveLimit + 1);
  localparam logic [CntWidth-1:0] Limit = CntWidth'(StarveLimit);

  for (genvar g = 0; g < NumReq; g++) begin : g_starve
    logic [CntWidth-1:0] wait_q;
    logic [CntWidth-1:0] wait_d;
    logic                starve_q;

    always_comb begin
      wait_d = wait_q;
      if (!req_valid[g] || (grab && (pick == IdxWidth'(g)))) begin
        wait_d = '0;
      end else if (!(locked && (owner_q == IdxWidth'(g))) && (wait_q != '1)) begin
        wait_d = wait_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wait_q   <= '0;
        starve_q <= 1'b0;
      end else begin
        wait_q   <= wait_d;
        starve_q <= (wait_d >= Limit);
      end
    end

    assign starve[g] = starve_q;
  end
`else
  // The threshold only matters when the counters are built.
  logic unused_starve_limit;
  assign unused_starve_limit = ^StarveLimit;
  assign starve = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned Limit = 15;
`ifdef FIFO_ARB_STARVE_EN
  localparam bit StarveOn = 1'b1;
`else
  localparam bit StarveOn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_writeEn;
  logic [W-1:0]   fifo_writeData;
  logic           grant_valid;
  logic [1:0]     grant_idx;
  logic [N-1:0]   starve;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NumReq     (N),
    .DataWidth  (W),
    .StarveLimit(Limit)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .fifo_full     (fifo_full),
    .fifo_writeEn  (fifo_writeEn),
    .fifo_writeData(fifo_writeData),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .starve        (starve)
  );

  task automatic set_data(input int i, input logic [W-1:0] d);
    req_data[i*W +: W] = d;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
  endtask

  // Leaves the bench at a falling edge with rst just released and the DUT in IDLE.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'hF;
    req_last  = 4'hF;
    fifo_full = 1'b0;
    #1;
    n_total++;
    if ({fifo_writeEn, req_ready} !== 5'b0)
      $display("FAIL reset_gating got %b want 00000", {fifo_writeEn, req_ready});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({grant_valid, grant_idx, fifo_writeEn, req_ready, starve} !== 12'b0)
      $display("FAIL reset_state got %b want 0", {grant_valid, grant_idx, fifo_writeEn, req_ready,
                                                 starve});
    else n_pass++;
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_beat();
    logic [7:0]   exp_tab [6];
    logic [W-1:0] want;
    exp_tab = '{8'b0_00_0_0000, 8'b1_00_1_0001, 8'b0_00_0_0000,
                8'b1_10_1_0100, 8'b0_10_0_0000, 8'b1_00_1_0001};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = 4'b0101;
      req_last  = 4'b0101;
      set_data(0, 32'hC0DE_0000);
      set_data(2, 32'hC0DE_0002);
      #1;
      n_total++;
      if ({grant_valid, grant_idx, fifo_writeEn, req_ready} !== exp_tab[c])
        $display("FAIL single_beat_c%0d got %b want %b", c,
                 {grant_valid, grant_idx, fifo_writeEn, req_ready}, exp_tab[c]);
      else n_pass++;
      if (exp_tab[c][4]) begin
        want = (exp_tab[c][6:5] == 2'd0) ? 32'hC0DE_0000 : 32'hC0DE_0002;
        n_total++;
        if (fifo_writeData !== want)
          $display("FAIL single_beat_data_c%0d got %h want %h", c, fifo_writeData, want);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_packet_lock();
    logic [W-1:0] beats [3];
    beats = '{32'hA1, 32'hA2, 32'hA3};
    do_reset();
    req_valid = 4'b1010;
    req_last  = 4'b1000;
    set_data(1, beats[0]);
    set_data(3, 32'hD3);
    #1;
    n_total++;
    if ({grant_valid, fifo_writeEn} !== 2'b00)
      $display("FAIL lock_idle got %b want 00", {grant_valid, fifo_writeEn});
    else n_pass++;
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      set_data(1, beats[b]);
      req_last[1] = (b == 2);
      #1;
      n_total++;
      if ({grant_valid, grant_idx, fifo_writeEn, req_ready, fifo_writeData} !==
          {1'b1, 2'd1, 1'b1, 4'b0010, beats[b]})
        $display("FAIL lock_beat%0d got %b %h want 1_01_1_0010 %h", b,
                 {grant_valid, grant_idx, fifo_writeEn, req_ready}, fifo_writeData, beats[b]);
      else n_pass++;
      @(negedge clk);
    end
    req_valid = 4'b1000;
    #1;
    n_total++;
    if ({grant_valid, grant_idx, fifo_writeEn} !== 4'b0_01_0)
      $display("FAIL lock_release got %b want 0010", {grant_valid, grant_idx, fifo_writeEn});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({grant_valid, grant_idx, fifo_writeEn, fifo_writeData} !== {4'b1_11_1, 32'hD3})
      $display("FAIL lock_next_owner got %b %h want 1111 000000d3",
               {grant_valid, grant_idx, fifo_writeEn}, fifo_writeData);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    int   bi;
    logic exp_we;
    do_reset();
    bi        = 0;
    req_valid = 4'b0101;
    req_last  = 4'b0100;
    set_data(2, 32'hD2);
    set_data(0, 32'hB000_0000);
    #1;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      fifo_full = (c >= 2 && c <= 5);
      set_data(0, 32'hB000_0000 + 32'(bi));
      req_last[0] = (bi == 3);
      #1;
      exp_we = !fifo_full;
      n_total++;
      if ({grant_valid, grant_idx, fifo_writeEn, req_ready} !==
          {1'b1, 2'd0, exp_we, 3'b000, exp_we})
        $display("FAIL full_c%0d got %b want 1_00_%b_000%b", c,
                 {grant_valid, grant_idx, fifo_writeEn, req_ready}, exp_we, exp_we);
      else n_pass++;
      if (exp_we) begin
        n_total++;
        if (fifo_writeData !== 32'hB000_0000 + 32'(bi))
          $display("FAIL full_data_beat%0d got %h want %h", bi, fifo_writeData,
                   32'hB000_0000 + 32'(bi));
        else n_pass++;
        bi++;
      end
      @(negedge clk);
    end
    fifo_full = 1'b0;
    req_valid = 4'b0100;
    #1;
    n_total++;
    if ({grant_valid, fifo_writeEn} !== 2'b00)
      $display("FAIL full_release got %b want 00", {grant_valid, fifo_writeEn});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({grant_idx, fifo_writeEn, fifo_writeData} !== {2'd2, 1'b1, 32'hD2})
      $display("FAIL full_next got %b %h want 101 000000d2", {grant_idx, fifo_writeEn},
               fifo_writeData);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int         e;
    logic [3:0] oh;
    do_reset();
    req_valid = 4'hF;
    req_last  = 4'hF;
    for (int i = 0; i < 4; i++) set_data(i, 32'h5500_0000 + 32'(i));
    for (int g = 0; g < 5; g++) begin
      e  = g % 4;
      oh = 4'b0001 << e;
      #1;
      n_total++;
      if ({grant_valid, fifo_writeEn} !== 2'b00)
        $display("FAIL rr_idle%0d got %b want 00", g, {grant_valid, fifo_writeEn});
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if ({grant_valid, grant_idx, fifo_writeEn, req_ready, fifo_writeData} !==
          {1'b1, 2'(e), 1'b1, oh, 32'h5500_0000 + 32'(e)})
        $display("FAIL rr_grant%0d got idx %0d ready %b data %h want idx %0d", g, grant_idx,
                 req_ready, fifo_writeData, e);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    set_data(1, 32'h11);
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    set_data(2, 32'h20);
    #1;
    @(negedge clk);
    #1;
    n_total++;
    if ({grant_idx, fifo_writeEn, fifo_writeData} !== {2'd2, 1'b1, 32'h20})
      $display("FAIL midrst_beat0 got %b %h want 101 00000020", {grant_idx, fifo_writeEn},
               fifo_writeData);
    else n_pass++;
    @(negedge clk);
    set_data(2, 32'h21);
    rst = 1'b1;
    #1;
    n_total++;
    if ({fifo_writeEn, req_ready} !== 5'b0)
      $display("FAIL midrst_gating got %b want 00000", {fifo_writeEn, req_ready});
    else n_pass++;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0110;
    req_last  = 4'b0110;
    #1;
    n_total++;
    if ({grant_valid, grant_idx, fifo_writeEn} !== 4'b0)
      $display("FAIL midrst_after got %b want 0000", {grant_valid, grant_idx, fifo_writeEn});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({grant_valid, grant_idx} !== 3'b1_01)
      $display("FAIL midrst_first_grant got %b want 101", {grant_valid, grant_idx});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_starve();
    do_reset();
    set_data(1, 32'h51);
    for (int c = 0; c <= 22; c++) begin
      req_valid = {2'b00, 1'b1, (c <= 20)};
      req_last  = {2'b00, 1'b1, (c == 20)};
      set_data(0, 32'h5A00_0000 + 32'(c));
      #1;
      if (c >= 1 && c <= 20) begin
        n_total++;
        if ({grant_valid, grant_idx, fifo_writeEn, fifo_writeData} !==
            {4'b1_00_1, 32'h5A00_0000 + 32'(c)})
          $display("FAIL starve_owner_c%0d got %b %h", c, {grant_valid, grant_idx, fifo_writeEn},
                   fifo_writeData);
        else n_pass++;
      end
      if (c == 14 || c == 15 || c == 21 || c == 22) begin
        n_total++;
        if (starve !== {2'b00, StarveOn && (c == 15 || c == 21), 1'b0})
          $display("FAIL starve_flag_c%0d got %b want %b", c, starve,
                   {2'b00, StarveOn && (c == 15 || c == 21), 1'b0});
        else n_pass++;
      end
      if (c == 22) begin
        n_total++;
        if ({grant_valid, grant_idx} !== 3'b1_01)
          $display("FAIL starve_grant got %b want 101", {grant_valid, grant_idx});
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit           m_locked;
    int           m_owner, m_last, pick, cnd;
    int           m_cnt [N];
    logic [N-1:0] m_starve, e_ready;
    logic         e_we;
    bit           active [N];
    bit           vis [N];
    int           left [N];
    logic [W-1:0] cur [N];
    do_reset();
    m_locked = 0; m_owner = 0; m_last = N - 1; m_starve = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; active[i] = 0; vis[i] = 0; left[i] = 0; cur[i] = '0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!active[i] && $urandom_range(0, 4) == 0) begin
          active[i] = 1;
          left[i]   = $urandom_range(1, 5);
        end
        if (active[i] && !vis[i] && $urandom_range(0, 3) != 0) begin
          vis[i] = 1;
          cur[i] = $urandom;
        end
        req_valid[i] = vis[i];
        req_last[i]  = vis[i] && (left[i] == 1);
        set_data(i, cur[i]);
      end
      #1;
      e_we    = m_locked && req_valid[m_owner] && !fifo_full;
      e_ready = (m_locked && !fifo_full) ? (4'b0001 << m_owner) : 4'b0000;
      n_total++;
      if ({grant_valid, grant_idx, fifo_writeEn, req_ready, starve} !==
          {m_locked, 2'(m_owner), e_we, e_ready, m_starve})
        $display("FAIL rand_c%0d got %b want %b", cyc,
                 {grant_valid, grant_idx, fifo_writeEn, req_ready, starve},
                 {m_locked, 2'(m_owner), e_we, e_ready, m_starve});
      else n_pass++;
      if (e_we) begin
        n_total++;
        if (fifo_writeData !== cur[m_owner])
          $display("FAIL rand_data_c%0d got %h want %h", cyc, fifo_writeData, cur[m_owner]);
        else n_pass++;
      end
      // Reference: round-robin search from the last granted requester, packet-long locks.
      pick = m_last;
      for (int k = N; k > 0; k--) begin
        cnd = (m_last + k) % N;
        if (req_valid[cnd]) pick = cnd;
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || (!m_locked && pick == i)) m_cnt[i] = 0;
        else if (!(m_locked && m_owner == i)) m_cnt[i]++;
        m_starve[i] = StarveOn && (m_cnt[i] >= Limit);
      end
      if (e_we) begin
        left[m_owner]--;
        vis[m_owner] = 0;
        if (left[m_owner] == 0) active[m_owner] = 0;
      end
      if (!m_locked) begin
        if (|req_valid) begin
          m_locked = 1;
          m_owner  = pick;
        end
      end else if (e_we && req_last[m_owner]) begin
        m_locked = 0;
        m_last   = m_owner;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_fifo_full();
    test_round_robin();
    test_reset_mid_packet();
    test_starve();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
